mem_port_arbiter: RTL

- Shares one single-ported unified memory between the processor's instruction-fetch port and its data-access port.
- Grants one transaction at a time. Data accesses have priority; a starvation guard periodically forces a fetch grant.
- Returns a one-cycle done pulse plus registered read data to each requester.
- The processor holds its pipeline stalled while a port's request is high and its done has not yet arrived.

---
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Data wins by default; a streak counter forces a fetch grant after D_STREAK data wins.
module mem_port_arbiter #(
    parameter int LAT      = 2,
    parameter int D_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic [3:0]  d_byteen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  owner
);
    localparam logic [3:0] LAT_M1     = 4'(LAT - 1);
    localparam logic [3:0] STREAK_MAX = 4'(D_STREAK);
    localparam logic [1:0] OWN_I      = 2'b01;
    localparam logic [1:0] OWN_D      = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t     state;
    logic [3:0] wait_cnt;
    logic [3:0] streak;
    logic       data_win;

    // fetch only beats a pending data request once the streak has saturated
    always_comb data_win = d_req && !(i_req && streak == STREAK_MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            streak     <= '0;
            i_rdata    <= '0;
            i_done     <= 1'b0;
            d_rdata    <= '0;
            d_done     <= 1'b0;
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            mem_byteen <= '0;
            mem_wdata  <= '0;
            owner      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        if (data_win) begin
                            owner      <= OWN_D;
                            mem_addr   <= d_addr & 32'hFFFF_FFFC;
                            mem_byteen <= d_byteen;
                            mem_wdata  <= d_wdata;
                            if (i_req && streak != STREAK_MAX)
                                streak <= streak + 4'd1;
                        end else begin
                            owner      <= OWN_I;
                            mem_addr   <= i_addr & 32'hFFFF_FFFC;
                            mem_byteen <= '0;
                            mem_wdata  <= '0;
                            streak     <= '0;
                        end
                        mem_en <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en   <= 1'b0;
                    wait_cnt <= LAT_M1;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        // loads capture; stores leave the requester's rdata untouched
                        if (mem_byteen == '0) begin
                            if (owner == OWN_I) i_rdata <= mem_rdata;
                            else                d_rdata <= mem_rdata;
                        end
                        if (owner == OWN_I) i_done <= 1'b1;
                        else                d_done <= 1'b1;
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    i_done <= 1'b0;
                    d_done <= 1'b0;
                    owner  <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
